// File: rtl/feature_bank_loader.sv
// feature_bank_loader: banked feature memory for the HD accelerator front end.
// A load streams DIV_SIZE words in on a valid/ready handshake and spreads them
// round-robin over NUM_BANKS single-port banks (word k -> bank k%NB, row k/NB).
// Outside a load, a read returns one full row (one word per bank) one cycle later.
module feature_bank_loader #(
   parameter int NUM_BANKS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int DIV_SIZE   = 512,
   parameter int CNT_WIDTH  = $clog2(DIV_SIZE + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             in_valid,
   input  logic [DATA_WIDTH-1:0]            in_data,
   output logic                             in_ready,
   input  logic                             rd_en,
   input  logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic                             rd_valid,
   output logic [NUM_BANKS*DATA_WIDTH-1:0]  rd_data,
   output logic                             load_busy,
   output logic                             load_done,
   output logic [CNT_WIDTH-1:0]             load_count,
   output logic                             err_proto
);

   localparam int ROWS   = DIV_SIZE / NUM_BANKS;
   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam logic [ADDR_WIDTH:0]   ROWS_L    = (ADDR_WIDTH + 1)'(ROWS);
   localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(NUM_BANKS - 1);
   localparam logic [CNT_WIDTH-1:0]  LAST_WORD = CNT_WIDTH'(DIV_SIZE - 1);

   // Reject geometries where a load cannot be laid out as whole rows in the banks.
   if ((NUM_BANKS < 1) || ((DIV_SIZE % NUM_BANKS) != 0) ||
       (DIV_SIZE > NUM_BANKS * DEPTH)) begin : g_bad_params
      $error("feature_bank_loader: illegal NUM_BANKS/DIV_SIZE/ADDR_WIDTH combination");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                            state_q, state_d;
   logic [CNT_WIDTH-1:0]              load_count_q, load_count_d;
   logic [BANK_W-1:0]                 bank_q, bank_d;
   logic [ADDR_WIDTH-1:0]             row_q, row_d;
   logic                              err_q, err_d;
   logic                              rd_valid_q, rd_valid_d;
   logic [NUM_BANKS*DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

   logic                              wr_en_s;
   logic                              rd_hit_s;
   logic                              rd_oor_s;
   logic [ADDR_WIDTH-1:0]             ram_addr_s;
   logic [NUM_BANKS*DATA_WIDTH-1:0]   rd_row_s;

   // Handshake and read qualification; the single bank port is shared by
   // using the write pointer only in LOAD and the read address otherwise.
   always_comb begin
      wr_en_s    = (state_q == S_LOAD) && in_valid && !start;
      rd_hit_s   = rd_en && (state_q != S_LOAD);
      rd_oor_s   = ({1'b0, rd_addr} >= ROWS_L);
      if (state_q == S_LOAD) begin
         ram_addr_s = row_q;
      end else begin
         ram_addr_s = rd_addr;
      end
   end

   for (genvar j = 0; j < NUM_BANKS; j++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem_q [DEPTH];

      // Write the accepted word when the round-robin pointer selects this bank.
      always_ff @(posedge clk) begin
         if (wr_en_s && (bank_q == BANK_W'(j))) begin
            mem_q[ram_addr_s] <= in_data;
         end
      end

      assign rd_row_s[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[ram_addr_s];
   end

   // Next-state logic: load sequencing, pointers, read capture and error flag.
   always_comb begin
      state_d      = state_q;
      load_count_d = load_count_q;
      bank_d       = bank_q;
      row_d        = row_q;
      err_d        = err_q;
      rd_valid_d   = 1'b0;
      rd_data_d    = rd_data_q;

      if (rd_hit_s) begin
         rd_valid_d = 1'b1;
         if (rd_oor_s) begin
            rd_data_d = '0;
            err_d     = 1'b1;
         end else begin
            rd_data_d = rd_row_s;
         end
      end else begin
         rd_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_LOAD;
               load_count_d = '0;
               bank_d       = '0;
               row_d        = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (start) begin
               // Restart: the word presented alongside start is dropped.
               load_count_d = '0;
               bank_d       = '0;
               row_d        = '0;
            end else if (wr_en_s) begin
               load_count_d = load_count_q + CNT_WIDTH'(1);
               if (bank_q == LAST_BANK) begin
                  bank_d = '0;
                  row_d  = row_q + ADDR_WIDTH'(1);
               end else begin
                  bank_d = bank_q + BANK_W'(1);
               end
               if (load_count_q == LAST_WORD) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            if (start) begin
               state_d      = S_LOAD;
               load_count_d = '0;
               bank_d       = '0;
               row_d        = '0;
            end else if (in_valid) begin
               // Data beyond a complete load is a protocol violation and is dropped.
               err_d = 1'b1;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset; RAM is left untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         load_count_q <= '0;
         bank_q       <= '0;
         row_q        <= '0;
         err_q        <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         load_count_q <= load_count_d;
         bank_q       <= bank_d;
         row_q        <= row_d;
         err_q        <= err_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
      end
   end

   assign in_ready   = (state_q == S_LOAD);
   assign load_busy  = (state_q == S_LOAD);
   assign load_done  = (state_q == S_DONE);
   assign load_count = load_count_q;
   assign err_proto  = err_q;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_feature_bank_loader.sv
// Testbench for feature_bank_loader: behavioural model plus a read scoreboard.
// Inputs are driven on the falling edge; outputs are checked on the falling edge.
module tb_feature_bank_loader;

   localparam int NB   = 4;
   localparam int DW   = 32;
   localparam int AW   = 8;
   localparam int DIV  = 512;
   localparam int CW   = $clog2(DIV + 1);
   localparam int ROWS = DIV / NB;

   logic              clk;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic [DW-1:0]     in_data;
   logic              in_ready;
   logic              rd_en;
   logic [AW-1:0]     rd_addr;
   logic              rd_valid;
   logic [NB*DW-1:0]  rd_data;
   logic              load_busy;
   logic              load_done;
   logic [CW-1:0]     load_count;
   logic              err_proto;

   feature_bank_loader #(
      .NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIV_SIZE(DIV)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_data(rd_data), .load_busy(load_busy),
      .load_done(load_done), .load_count(load_count), .err_proto(err_proto)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: 0 idle, 1 load, 2 done
   int                 m_state;
   int                 m_count;
   logic               m_err;
   logic [DW-1:0]      m_mem [DIV];
   logic [NB*DW-1:0]   m_last;
   logic [NB*DW-1:0]   exp_q [$];

   int n_vec;
   int n_err;
   int rdy_seen;

   task automatic chk(input string tag, input logic [NB*DW-1:0] obs,
                      input logic [NB*DW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NB*DW-1:0] model_row(input int a);
      logic [NB*DW-1:0] r;
      r = '0;
      for (int j = 0; j < NB; j++) r[j*DW +: DW] = m_mem[a*NB + j];
      return r;
   endfunction

   task automatic check_outputs();
      logic [NB*DW-1:0] e;
      chk("in_ready", {127'd0, in_ready}, {127'd0, (m_state == 1)});
      chk("load_busy", {127'd0, load_busy}, {127'd0, (m_state == 1)});
      chk("load_done", {127'd0, load_done}, {127'd0, (m_state == 2)});
      chk("load_count", 128'(load_count), 128'(m_count));
      chk("err_proto", {127'd0, err_proto}, {127'd0, m_err});
      if (in_ready) rdy_seen++;
      chk("rd_valid", {127'd0, rd_valid}, {127'd0, (exp_q.size() != 0)});
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("rd_data", rd_data, e);
         m_last = e;
      end else begin
         chk("rd_hold", rd_data, m_last);
      end
   endtask

   // One clock: check current outputs, drive inputs, advance the model.
   task automatic step(input logic st, input logic iv, input logic [DW-1:0] id,
                       input logic re, input logic [AW-1:0] ra);
      check_outputs();
      start = st; in_valid = iv; in_data = id; rd_en = re; rd_addr = ra;
      if (re && (m_state != 1)) begin
         if (int'(ra) >= ROWS) begin
            exp_q.push_back('0);
            m_err = 1'b1;
         end else begin
            exp_q.push_back(model_row(int'(ra)));
         end
      end
      case (m_state)
         0: if (st) begin m_state = 1; m_count = 0; end
         1: begin
            if (st) m_count = 0;
            else if (iv) begin
               m_mem[m_count] = id;
               m_count++;
               if (m_count == DIV) m_state = 2;
            end
         end
         2: begin
            if (st) begin m_state = 1; m_count = 0; end
            else if (iv) m_err = 1'b1;
         end
         default: m_state = 0;
      endcase
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input bit check_first);
      if (check_first) check_outputs();
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_state = 0; m_count = 0; m_err = 1'b0; m_last = '0;
      exp_q.delete();
      chk("rst_count", 128'(load_count), 128'd0);
      chk("rst_flags", {122'd0, in_ready, rd_valid, load_busy, load_done, err_proto, 1'b0}, 128'd0);
      chk("rst_rd_data", rd_data, 128'd0);
   endtask

   task automatic load_words(input int n, input int base, input bit gaps);
      int budget;
      logic iv;
      budget = 0;
      while (m_state == 1 && m_count < n && budget < 4*n + 50) begin
         iv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         step(1'b0, iv, DW'(base + m_count), 1'b0, '0);
         budget++;
      end
      if (m_count < n) chk("load_budget", 128'(m_count), 128'(n));
   endtask

   task automatic read_all();
      for (int a = 0; a < ROWS; a++) step(1'b0, 1'b0, '0, 1'b1, AW'(a));
      step(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0; rdy_seen = 0;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      @(posedge clk);
      @(negedge clk);
      do_reset(1'b0);

      // Full contiguous load of word i
      rdy_seen = 0;
      step(1'b1, 1'b0, '0, 1'b0, '0);
      load_words(DIV, 0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b0, '0, 1'b0, '0);
      chk("rdy_cycles", 128'(rdy_seen), 128'd512);
      chk("done_after_load", {127'd0, load_done}, 128'd1);
      chk("count_full", 128'(load_count), 128'd512);
      chk("err_clean", {127'd0, err_proto}, 128'd0);

      // Single read of row 5, then back-to-back sweep
      step(1'b0, 1'b0, '0, 1'b1, 8'd5);
      chk("row5", rd_data, {32'd23, 32'd22, 32'd21, 32'd20});
      chk("row5_valid", {127'd0, rd_valid}, 128'd1);
      read_all();

      // Load with random gaps
      step(1'b1, 1'b0, '0, 1'b0, '0);
      load_words(256, 0, 1'b1);
      chk("count_256", 128'(load_count), 128'd256);
      load_words(DIV, 0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1, 8'd5);
      chk("row5_gaps", rd_data, {32'd23, 32'd22, 32'd21, 32'd20});
      read_all();

      // Restart after 100 accepts, then reload 1000+i
      step(1'b1, 1'b0, '0, 1'b0, '0);
      load_words(100, 0, 1'b0);
      step(1'b1, 1'b1, 32'h0BAD, 1'b0, '0);
      chk("restart_count", 128'(load_count), 128'd0);
      load_words(DIV, 1000, 1'b0);
      chk("restart_done", {127'd0, load_done}, 128'd1);
      step(1'b0, 1'b0, '0, 1'b1, 8'd0);
      chk("row0_restart", rd_data, {32'd1003, 32'd1002, 32'd1001, 32'd1000});

      // Excess data in DONE and an out-of-range read
      step(1'b0, 1'b1, 32'hDEAD, 1'b0, '0);
      step(1'b0, 1'b0, '0, 1'b1, 8'd0);
      chk("err_excess", {127'd0, err_proto}, 128'd1);
      chk("row0_after_excess", rd_data, {32'd1003, 32'd1002, 32'd1001, 32'd1000});
      read_all();
      step(1'b0, 1'b0, '0, 1'b1, 8'd200);
      chk("oor_data", rd_data, 128'd0);
      chk("oor_valid", {127'd0, rd_valid}, 128'd1);

      // Reset mid-load at 300 accepts; partial RAM contents survive
      do_reset(1'b1);
      step(1'b1, 1'b0, '0, 1'b0, '0);
      load_words(300, 0, 1'b0);
      do_reset(1'b1);
      step(1'b0, 1'b0, '0, 1'b1, 8'd0);
      chk("row0_partial", rd_data, {32'd3, 32'd2, 32'd1, 32'd0});
      chk("row0_partial_v", {127'd0, rd_valid}, 128'd1);
      step(1'b1, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b0, '0, 1'b1, 8'd3);
      chk("rd_in_load_v", {127'd0, rd_valid}, 128'd0);
      chk("rd_in_load_hold", rd_data, {32'd3, 32'd2, 32'd1, 32'd0});
      step(1'b0, 1'b0, '0, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/feature_bank_loader.md
Name: feature_bank_loader

Overview:
- Parametrised banked feature memory for the HD accelerator front end.
- Accepts a stream of DIV_SIZE feature words on a valid/ready handshake and distributes them round-robin across NUM_BANKS single-port RAM banks.
- After loading, returns one full row (one word per bank) per read with fixed one-cycle latency.
- Adds explicit start/restart, backpressure, load progress count and protocol-error flagging.

Parameters:
- NUM_BANKS, 4, number of banks / words per read row; must be at least 1.
- DATA_WIDTH, 32, bits per feature word.
- ADDR_WIDTH, 8, row address width; bank depth is 2**ADDR_WIDTH.
- DIV_SIZE, 512, feature words per load; must be a multiple of NUM_BANKS and at most NUM_BANKS*2**ADDR_WIDTH, otherwise elaboration fails.
- CNT_WIDTH, $clog2(DIV_SIZE+1), width of load_count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a new load.
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_WIDTH  feature word.
- in_ready  output  1  block accepts a word this cycle.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  row address.
- rd_valid  output  1  rd_data holds the result of the previous cycle's read.
- rd_data  output  NUM_BANKS*DATA_WIDTH  bank j occupies bits [j*DATA_WIDTH +: DATA_WIDTH].
- load_busy  output  1  state is LOAD.
- load_done  output  1  state is DONE.
- load_count  output  CNT_WIDTH  words accepted in the current load.
- err_proto  output  1  sticky error flag; cleared only by reset.

Behaviour:
- States: IDLE, LOAD, DONE. Reset enters IDLE.
- Reset values: in_ready=0, rd_valid=0, rd_data=0, load_busy=0, load_done=0, load_count=0, err_proto=0. RAM contents are not cleared.
- IDLE -> LOAD on start. DONE -> LOAD on start.
- start while in LOAD restarts the load: next cycle load_count=0 and the bank/row pointers return to 0. Any word presented in the same cycle as start is not accepted.
- in_ready = (state==LOAD) and is purely combinational from state.
- Accept = in_valid & in_ready. Accepted word number k (0-based) is written to bank k mod NUM_BANKS at row k / NUM_BANKS in the same clock edge.
- load_count increments by 1 per accept.
- On the accept with k = DIV_SIZE-1: the next cycle is DONE, load_count=DIV_SIZE, in_ready=0.
- No skipped or duplicated writes under arbitrary in_valid gaps.
- err_proto is set on in_valid=1 while state is DONE and start=0 (excess data). Excess data is never written.
- Reads:
  - rd_en is honoured in IDLE and DONE. rd_en in LOAD is ignored: rd_valid=0 next cycle and rd_data holds.
  - Latency 1: an rd_en at cycle t gives rd_valid=1 and the row rd_addr on rd_data at cycle t+1.
  - rd_data holds its last value when no read is performed. rd_valid is 0 in any cycle not following an honoured read.
  - rd_addr >= DIV_SIZE/NUM_BANKS returns all-zero rd_data with rd_valid=1 and sets err_proto.
- Back-to-back reads every cycle are supported at full throughput.
- Reset asserted mid-load aborts the load: next cycle is IDLE with outputs at their reset values. Partially written RAM contents persist.
- start and rd_en in the same cycle in DONE: the read is performed (rd_valid=1 next cycle, old data) and the state becomes LOAD.
- Each bank has a single port. The write address is used only in LOAD and the read address only outside LOAD, so there are no port conflicts.

Test Plan:
- Defaults. reset, then start, then 512 words with in_data=i, in_valid held high -> in_ready=1 for exactly 512 cycles, load_done=1 the cycle after the last accept, load_count=512, err_proto=0.
- After that load, rd_en with rd_addr=5 -> next cycle rd_valid=1 and rd_data bank0..3 = 20,21,22,23. Reads of addresses 0..127 on consecutive cycles -> row a returns 4a..4a+3 with no bubbles.
- Load with in_valid toggling on a pseudo-random pattern of 50% gaps -> identical RAM contents to the first test. load_count=256 after 256 accepts.
- Restart mid-load: start again after 100 accepts, then feed 512 words with value 1000+i -> row 0 = 1000,1001,1002,1003 and load_done after exactly 512 accepts from the restart.
- In DONE, drive in_valid=1 with in_data=0xDEAD -> err_proto=1 and all reads unchanged. rd_addr=200 -> rd_data=0, rd_valid=1.
- Reset at accept 300, then rd_en with rd_addr=0 in IDLE -> rd_valid=1 and row 0 = 0,1,2,3. rd_en during LOAD -> rd_valid stays 0.
